// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the architectural PC, fetches one word at a
// time from instruction memory and hands each instruction (or fault) to decode.
module fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] o_pc,
  input  logic [XLEN-1:0] i_pc_next,
  input  logic            i_advance,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [31:0]     i_imem_rsp_data,
  input  logic            i_imem_rsp_err,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [31:0]     o_id_instr,
  output logic [XLEN-1:0] o_id_pc,
  output logic [1:0]      o_id_fault
);

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [1:0]  FAULT_NONE  = 2'd0;
  localparam logic [1:0]  FAULT_ALIGN = 2'd1;
  localparam logic [1:0]  FAULT_BUS   = 2'd2;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_EXEC = 3'd4
  } state_t;

  state_t          r_state,    w_state_next;
  logic [XLEN-1:0] r_pc,       w_pc_next;
  logic [XLEN-1:0] r_req_addr, w_req_addr_next;
  logic            r_discard,  w_discard_next;
  logic [31:0]     r_id_instr, w_id_instr_next;
  logic [XLEN-1:0] r_id_pc,    w_id_pc_next;
  logic [1:0]      r_id_fault, w_id_fault_next;

  // Redirect target for the current cycle (flush wins over advance / stale pc)
  logic [XLEN-1:0] w_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_discard  <= 1'b0;
      r_id_instr <= NOP;
      r_id_pc    <= RESET_PC;
      r_id_fault <= FAULT_NONE;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
      r_discard  <= w_discard_next;
      r_id_instr <= w_id_instr_next;
      r_id_pc    <= w_id_pc_next;
      r_id_fault <= w_id_fault_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_req_addr_next = r_req_addr;
    w_discard_next  = r_discard;
    w_id_instr_next = r_id_instr;
    w_id_pc_next    = r_id_pc;
    w_id_fault_next = r_id_fault;
    w_target        = i_flush ? i_flush_pc : r_pc;

    case (r_state)
      S_BOOT: w_state_next = S_REQ;

      S_REQ: begin
        // The request is never retracted; a flush just marks its response stale
        if (i_flush) begin
          w_pc_next      = i_flush_pc;
          w_discard_next = 1'b1;
        end
        if (i_imem_req_ready) w_state_next = S_WAIT;
      end

      S_WAIT: begin
        if (i_imem_rsp_valid) begin
          if (i_flush || r_discard) begin
            w_pc_next      = w_target;
            w_discard_next = 1'b0;
            if (w_target[1:0] != 2'b00) begin
              w_id_instr_next = NOP;
              w_id_pc_next    = w_target;
              w_id_fault_next = FAULT_ALIGN;
              w_state_next    = S_HOLD;
            end else begin
              w_req_addr_next = w_target;
              w_state_next    = S_REQ;
            end
          end else begin
            w_id_instr_next = i_imem_rsp_err ? NOP : i_imem_rsp_data;
            w_id_pc_next    = r_req_addr;
            w_id_fault_next = i_imem_rsp_err ? FAULT_BUS : FAULT_NONE;
            w_state_next    = S_HOLD;
          end
        end else if (i_flush) begin
          w_pc_next      = i_flush_pc;
          w_discard_next = 1'b1;
        end
      end

      S_HOLD, S_EXEC: begin
        if (r_state == S_EXEC && !i_flush) w_target = i_pc_next;
        if (i_flush || (r_state == S_EXEC && i_advance)) begin
          w_pc_next = w_target;
          if (w_target[1:0] != 2'b00) begin
            w_id_instr_next = NOP;
            w_id_pc_next    = w_target;
            w_id_fault_next = FAULT_ALIGN;
            w_state_next    = S_HOLD;
          end else begin
            w_req_addr_next = w_target;
            w_state_next    = S_REQ;
          end
        end else if (r_state == S_HOLD && i_id_ready) begin
          w_state_next = S_EXEC;
        end
      end

      default: w_state_next = S_BOOT;
    endcase
  end

  always_comb begin
    o_imem_req_valid = (r_state == S_REQ);
    o_id_valid       = (r_state == S_HOLD);
  end

  assign o_pc            = r_pc;
  assign o_imem_req_addr = r_req_addr;
  assign o_id_instr      = r_id_instr;
  assign o_id_pc         = r_id_pc;
  assign o_id_fault      = r_id_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: fetch, advance, backpressure,
// misalignment, bus error, flush and mid-transaction reset scenarios.
module tb_fetch_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            advance;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [1:0]      id_fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_pc             (pc),
    .i_pc_next        (pc_next),
    .i_advance        (advance),
    .i_flush          (flush),
    .i_flush_pc       (flush_pc),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_imem_rsp_err   (rsp_err),
    .o_id_valid       (id_valid),
    .i_id_ready       (id_ready),
    .o_id_instr       (id_instr),
    .o_id_pc          (id_pc),
    .o_id_fault       (id_fault)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pc_next = '0; advance = 0; flush = 0; flush_pc = '0;
    req_ready = 1; rsp_valid = 0; rsp_data = '0; rsp_err = 0; id_ready = 0;
    repeat (3) tick();
    n_vec++;
    if ({req_valid, id_valid, id_fault} !== 4'b0 || pc !== 32'h0 || req_addr !== 32'h0
        || id_instr !== 32'h13 || id_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h addr=%h rv=%b iv=%b instr=%h idpc=%h flt=%0d, required 0/0/0/0/00000013/0/0",
               pc, req_addr, req_valid, id_valid, id_instr, id_pc, id_fault);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL first_req: valid=%b addr=%h, required 1 00000000", req_valid, req_addr);
    end
  endtask

  task automatic test_first_fetch;
    tick();   // handshake -> WAIT
    n_vec++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wait_no_req: valid=%b, required 0", req_valid);
    end
    tick();
    rsp_valid = 1; rsp_data = 32'h00500093;
    tick();
    rsp_valid = 0;
    n_vec++;
    if (id_valid !== 1'b1 || id_instr !== 32'h00500093 || id_pc !== 32'h0 || id_fault !== 2'd0) begin
      n_err++;
      $display("FAIL first_instr: iv=%b instr=%h pc=%h flt=%0d, required 1 00500093 00000000 0",
               id_valid, id_instr, id_pc, id_fault);
    end
  endtask

  task automatic test_advance_backpressure;
    id_ready = 1;
    tick();   // HOLD -> EXEC
    id_ready = 0;
    n_vec++;
    if (id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL exec_id_valid: iv=%b, required 0", id_valid);
    end
    pc_next = 32'h104; advance = 1;
    tick();
    advance = 0; req_ready = 0;
    n_vec++;
    if (pc !== 32'h104 || req_valid !== 1'b1 || req_addr !== 32'h104) begin
      n_err++;
      $display("FAIL advance: pc=%h rv=%b addr=%h, required 00000104 1 00000104", pc, req_valid, req_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (req_valid !== 1'b1 || req_addr !== 32'h104) begin
        n_err++;
        $display("FAIL req_stall%0d: rv=%b addr=%h, required 1 00000104", i, req_valid, req_addr);
      end
    end
    req_ready = 1;
    tick();
    rsp_valid = 1; rsp_data = 32'h00a00113;
    tick();
    rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (id_valid !== 1'b1 || id_instr !== 32'h00a00113 || id_pc !== 32'h104 || id_fault !== 2'd0) begin
        n_err++;
        $display("FAIL hold_stable%0d: iv=%b instr=%h pc=%h flt=%0d, required 1 00a00113 00000104 0",
                 i, id_valid, id_instr, id_pc, id_fault);
      end
      if (i < 2) tick();
    end
    id_ready = 1;
    tick();
    id_ready = 0;
  endtask

  task automatic test_misaligned;
    pc_next = 32'h106; advance = 1;
    tick();
    advance = 0;
    n_vec++;
    if (req_valid !== 1'b0 || id_valid !== 1'b1 || id_instr !== 32'h13 || id_pc !== 32'h106
        || id_fault !== 2'd1 || pc !== 32'h106) begin
      n_err++;
      $display("FAIL misaligned: rv=%b iv=%b instr=%h idpc=%h flt=%0d pc=%h, required 0 1 00000013 00000106 1 00000106",
               req_valid, id_valid, id_instr, id_pc, id_fault, pc);
    end
    id_ready = 1;
    tick();
    id_ready = 0;
  endtask

  task automatic test_bus_error;
    pc_next = 32'h10; advance = 1;
    tick();
    advance = 0;
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== 32'h10) begin
      n_err++;
      $display("FAIL berr_req: rv=%b addr=%h, required 1 00000010", req_valid, req_addr);
    end
    tick();
    rsp_valid = 1; rsp_err = 1; rsp_data = 32'hdeadbeef;
    tick();
    rsp_valid = 0; rsp_err = 0;
    n_vec++;
    if (id_valid !== 1'b1 || id_instr !== 32'h13 || id_pc !== 32'h10 || id_fault !== 2'd2) begin
      n_err++;
      $display("FAIL bus_error: iv=%b instr=%h pc=%h flt=%0d, required 1 00000013 00000010 2",
               id_valid, id_instr, id_pc, id_fault);
    end
    id_ready = 1;
    tick();
    id_ready = 0;
  endtask

  task automatic test_flush_wait;
    pc_next = 32'h10; advance = 1;
    tick();   // -> REQ
    advance = 0;
    tick();   // -> WAIT
    flush = 1; flush_pc = 32'h200;
    tick();
    flush = 0;
    n_vec++;
    if (pc !== 32'h200 || req_valid !== 1'b0 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_wait: pc=%h rv=%b iv=%b, required 00000200 0 0", pc, req_valid, id_valid);
    end
    tick();
    rsp_valid = 1; rsp_data = 32'hbadbad00;
    tick();
    rsp_valid = 0;
    n_vec++;
    if (id_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h200) begin
      n_err++;
      $display("FAIL stale_drop: iv=%b rv=%b addr=%h, required 0 1 00000200", id_valid, req_valid, req_addr);
    end
    tick();
    rsp_valid = 1; rsp_data = 32'h02000193;
    tick();
    rsp_valid = 0;
    n_vec++;
    if (id_valid !== 1'b1 || id_instr !== 32'h02000193 || id_pc !== 32'h200) begin
      n_err++;
      $display("FAIL flush_fetch: iv=%b instr=%h pc=%h, required 1 02000193 00000200", id_valid, id_instr, id_pc);
    end
    id_ready = 1;
    tick();
    id_ready = 0;
  endtask

  task automatic test_flush_with_rsp;
    pc_next = 32'h10; advance = 1;
    tick();
    advance = 0;
    tick();
    rsp_valid = 1; rsp_data = 32'hbadbad01; flush = 1; flush_pc = 32'h300;
    tick();
    rsp_valid = 0; flush = 0;
    n_vec++;
    if (id_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h300 || pc !== 32'h300) begin
      n_err++;
      $display("FAIL flush_coincident: iv=%b rv=%b addr=%h pc=%h, required 0 1 00000300 00000300",
               id_valid, req_valid, req_addr, pc);
    end
    tick();
    rsp_valid = 1; rsp_data = 32'h00300213;
    tick();
    rsp_valid = 0;
    n_vec++;
    if (id_valid !== 1'b1 || id_instr !== 32'h00300213 || id_pc !== 32'h300) begin
      n_err++;
      $display("FAIL coincident_fetch: iv=%b instr=%h pc=%h, required 1 00300213 00000300", id_valid, id_instr, id_pc);
    end
  endtask

  task automatic test_flush_hold_misaligned;
    // Still in HOLD: a misaligned flush goes straight to the fault path
    flush = 1; flush_pc = 32'h302;
    tick();
    flush = 0;
    n_vec++;
    if (id_valid !== 1'b1 || id_fault !== 2'd1 || id_pc !== 32'h302 || id_instr !== 32'h13
        || req_valid !== 1'b0 || pc !== 32'h302) begin
      n_err++;
      $display("FAIL flush_misaligned: iv=%b flt=%0d idpc=%h instr=%h rv=%b pc=%h, required 1 1 00000302 00000013 0 00000302",
               id_valid, id_fault, id_pc, id_instr, req_valid, pc);
    end
  endtask

  task automatic test_reset_midflight;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (id_valid !== 1'b0 || req_valid !== 1'b0 || pc !== 32'h0 || id_instr !== 32'h13
        || id_pc !== 32'h0 || id_fault !== 2'd0 || req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: iv=%b rv=%b pc=%h instr=%h idpc=%h flt=%0d addr=%h, required 0 0 0 00000013 0 0 0",
               id_valid, req_valid, pc, id_instr, id_pc, id_fault, req_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    rsp_valid = 1; rsp_data = 32'hbadbad02;   // stray response while in BOOT
    tick();
    rsp_valid = 0;
    n_vec++;
    if (req_valid !== 1'b1 || id_valid !== 1'b0 || req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset_req: rv=%b iv=%b addr=%h, required 1 0 00000000", req_valid, id_valid, req_addr);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_advance_backpressure();
    test_misaligned();
    test_bus_error();
    test_flush_wait();
    test_flush_with_rsp();
    test_flush_hold_misaligned();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
